// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared opcodes, decoded record and buffer states for the TL45 decode stage
package tl45_pkg;

  // pc/imm are carried at this width inside the record; XLEN may range up to it.
  localparam int MAX_XLEN = 64;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_NAND   = 4'h1;
  localparam logic [3:0] OP_ADDI   = 4'h2;
  localparam logic [3:0] OP_LW     = 4'h3;
  localparam logic [3:0] OP_SW     = 4'h4;
  localparam logic [3:0] OP_GOTO   = 4'h5;
  localparam logic [3:0] OP_JALR   = 4'h6;
  localparam logic [3:0] OP_HALT   = 4'h7;
  localparam logic [3:0] OP_SKP    = 4'h8;
  localparam logic [3:0] OP_LEA    = 4'h9;
  localparam logic [3:0] OP_BUBBLE = 4'hF;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [3:0]          opcode;
    logic                skp_mode;
    logic [3:0]          dr;
    logic [3:0]          sr1;
    logic [3:0]          sr2;
    logic [MAX_XLEN-1:0] imm;
    logic                illegal;
  } decoded_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_e;

  function automatic decoded_t bubble_dec();
    decoded_t d;
    d        = '0;
    d.opcode = OP_BUBBLE;
    return d;
  endfunction

endpackage

// File: rtl/tl45_inst_decoder.sv
// rtl/tl45_inst_decoder.sv - combinational TL45 instruction decode into a decoded_t record
import tl45_pkg::*;

module tl45_inst_decoder #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 16
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  output decoded_t        dec
);

  logic [ADDR_BITS-1:0] target;
  logic [XLEN-1:0]      imm_s20;
  logic [XLEN-1:0]      imm_rel;

  always_comb begin
    // PC-relative target wraps within ADDR_BITS before zero extension.
    target  = pc[ADDR_BITS-1:0] + inst[ADDR_BITS-1:0];
    imm_s20 = {{(XLEN-20){inst[19]}}, inst[19:0]};
    imm_rel = XLEN'(target);

    dec          = '0;
    dec.pc       = MAX_XLEN'(pc);
    dec.opcode   = inst[31:28];
    dec.skp_mode = inst[24];

    case (inst[31:28])
      OP_ADD, OP_NAND: begin
        dec.dr  = inst[27:24];
        dec.sr1 = inst[23:20];
        dec.sr2 = inst[3:0];
      end
      OP_ADDI, OP_LW: begin
        dec.dr  = inst[27:24];
        dec.sr1 = inst[23:20];
        dec.imm = MAX_XLEN'(imm_s20);
      end
      OP_SW: begin
        dec.sr1 = inst[23:20];
        dec.sr2 = inst[27:24];
        dec.imm = MAX_XLEN'(imm_s20);
      end
      OP_GOTO: begin
        dec.imm = MAX_XLEN'(imm_rel);
      end
      OP_LEA: begin
        dec.dr  = inst[27:24];
        dec.imm = MAX_XLEN'(imm_rel);
      end
      OP_JALR: begin
        dec.dr  = inst[27:24];
        dec.sr1 = inst[23:20];
      end
      OP_SKP: begin
        dec.sr1 = inst[23:20];
        dec.sr2 = inst[3:0];
      end
      OP_HALT: begin
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tl45_decode_hs.sv
// rtl/tl45_decode_hs.sv - TL45 decode stage with valid/ready handshake and optional skid entry
import tl45_pkg::*;

module tl45_decode_hs #(
  parameter int XLEN      = 32,
  parameter int ADDR_BITS = 16,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stage_flush,
  input  logic            i_pipe_flush,
  output logic            o_pipe_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_buf_pc,
  input  logic [31:0]     i_buf_inst,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_buf_pc,
  output logic [3:0]      o_buf_opcode,
  output logic            o_buf_skp_mode,
  output logic [3:0]      o_buf_dr,
  output logic [3:0]      o_buf_sr1,
  output logic [3:0]      o_buf_sr2,
  output logic [XLEN-1:0] o_buf_imm,
  output logic            o_buf_illegal
);

  decoded_t   dec_w;
  decoded_t   out_q, out_d;
  decoded_t   skid_q, skid_d;
  buf_state_e state_q, state_d;
  logic       flush;
  logic       accept;
  logic       drain;

  tl45_inst_decoder #(
    .XLEN      (XLEN),
    .ADDR_BITS (ADDR_BITS)
  ) u_dec (
    .pc   (i_buf_pc),
    .inst (i_buf_inst),
    .dec  (dec_w)
  );

  assign o_pipe_flush = i_pipe_flush;
  assign flush        = i_reset || i_stage_flush || i_pipe_flush;
  assign o_valid      = (state_q != BUF_EMPTY);

  generate
    if (SKID_EN) begin : g_skid
      assign o_ready = (state_q != BUF_FULL);
    end else begin : g_noskid
      assign o_ready = !o_valid || i_ready;
    end
  endgenerate

  assign accept = i_valid && o_ready;
  assign drain  = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
      out_d   = bubble_dec();
      skid_d  = bubble_dec();
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            out_d   = dec_w;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            out_d = dec_w;
          end else if (accept && SKID_EN) begin
            skid_d  = dec_w;
            state_d = BUF_FULL;
          end else if (drain) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            out_d   = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= BUF_EMPTY;
      out_q   <= bubble_dec();
      skid_q  <= bubble_dec();
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign o_buf_pc       = XLEN'(out_q.pc);
  assign o_buf_opcode   = out_q.opcode;
  assign o_buf_skp_mode = out_q.skp_mode;
  assign o_buf_dr       = out_q.dr;
  assign o_buf_sr1      = out_q.sr1;
  assign o_buf_sr2      = out_q.sr2;
  assign o_buf_imm      = XLEN'(out_q.imm);
  assign o_buf_illegal  = out_q.illegal;

endmodule

// File: tb/tb_tl45_decode_hs.sv
// tb/tb_tl45_decode_hs.sv - self-checking bench for tl45_decode_hs with and without the skid entry
module tb_tl45_decode_hs;

  localparam int AB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  vld, rdy, sf, pf;
  logic [31:0] pc_in   [2];
  logic [31:0] inst_in [2];
  logic        chk_en = 1'b0;
  logic [1:0]  accv;
  int          total = 0;
  int          bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic        skp;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  function automatic exp_t bubble();
    exp_t e;
    e    = '0;
    e.op = 4'hF;
    return e;
  endfunction

  function automatic exp_t model_dec(input logic [31:0] pc, input logic [31:0] inst);
    exp_t            e;
    longint unsigned tgt;
    logic [31:0]     s20;
    e     = '0;
    e.pc  = pc;
    e.op  = inst[31:28];
    e.skp = inst[24];
    tgt   = ({32'd0, pc} + {32'd0, inst}) % (64'd1 << AB);
    s20   = inst[19] ? ((inst & 32'h000F_FFFF) | 32'hFFF0_0000) : (inst & 32'h000F_FFFF);
    case (int'(inst[31:28]))
      0, 1:    begin e.dr = inst[27:24]; e.sr1 = inst[23:20]; e.sr2 = inst[3:0]; end
      2, 3:    begin e.dr = inst[27:24]; e.sr1 = inst[23:20]; e.imm = s20; end
      4:       begin e.sr1 = inst[23:20]; e.sr2 = inst[27:24]; e.imm = s20; end
      5:       begin e.imm = 32'(tgt); end
      6:       begin e.dr = inst[27:24]; e.sr1 = inst[23:20]; end
      7:       begin end
      8:       begin e.sr1 = inst[23:20]; e.sr2 = inst[3:0]; end
      9:       begin e.dr = inst[27:24]; e.imm = 32'(tgt); end
      default: begin e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Instance 0 has the skid entry, instance 1 is single-entry.
  for (genvar g = 0; g < 2; g++) begin : m
    logic        o_ready, o_valid, o_pipe_flush, o_skp, o_ill;
    logic [31:0] o_pc, o_imm;
    logic [3:0]  o_op, o_dr, o_sr1, o_sr2;
    exp_t        q[$];
    exp_t        shown;
    logic        acc;

    tl45_decode_hs #(
      .XLEN      (32),
      .ADDR_BITS (AB),
      .SKID_EN   (g == 0)
    ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_stage_flush  (sf[g]),
      .i_pipe_flush   (pf[g]),
      .o_pipe_flush   (o_pipe_flush),
      .i_valid        (vld[g]),
      .o_ready        (o_ready),
      .i_buf_pc       (pc_in[g]),
      .i_buf_inst     (inst_in[g]),
      .o_valid        (o_valid),
      .i_ready        (rdy[g]),
      .o_buf_pc       (o_pc),
      .o_buf_opcode   (o_op),
      .o_buf_skp_mode (o_skp),
      .o_buf_dr       (o_dr),
      .o_buf_sr1      (o_sr1),
      .o_buf_sr2      (o_sr2),
      .o_buf_imm      (o_imm),
      .o_buf_illegal  (o_ill)
    );

    function automatic logic exp_ready();
      if (g == 0) return q.size() < 2;
      return (q.size() == 0) || rdy[g];
    endfunction

    always @(posedge clk) begin
      automatic logic a, d;
      if (rst || sf[g] || pf[g]) begin
        q.delete();
        shown <= bubble();
        acc   <= 1'b0;
      end else begin
        a = vld[g] && exp_ready();
        d = (q.size() > 0) && rdy[g];
        if (d) void'(q.pop_front());
        if (a) q.push_back(model_dec(pc_in[g], inst_in[g]));
        if (q.size() > 0) shown <= q[0];
        acc <= a;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("d%0d.valid", g), 64'(o_valid), 64'(q.size() > 0));
        chk($sformatf("d%0d.ready", g), 64'(o_ready), 64'(exp_ready()));
        chk($sformatf("d%0d.pflush", g), 64'(o_pipe_flush), 64'(pf[g]));
        chk($sformatf("d%0d.pc", g), 64'(o_pc), 64'(shown.pc));
        chk($sformatf("d%0d.op", g), 64'(o_op), 64'(shown.op));
        chk($sformatf("d%0d.skp", g), 64'(o_skp), 64'(shown.skp));
        chk($sformatf("d%0d.dr", g), 64'(o_dr), 64'(shown.dr));
        chk($sformatf("d%0d.sr1", g), 64'(o_sr1), 64'(shown.sr1));
        chk($sformatf("d%0d.sr2", g), 64'(o_sr2), 64'(shown.sr2));
        chk($sformatf("d%0d.imm", g), 64'(o_imm), 64'(shown.imm));
        chk($sformatf("d%0d.ill", g), 64'(o_ill), 64'(shown.ill));
      end
    end
  end

  assign accv = {m[1].acc, m[0].acc};

  task automatic drv(input int d, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic r, input logic s, input logic p);
    @(posedge clk);
    #2;
    vld[d]     = v;
    pc_in[d]   = pc;
    inst_in[d] = inst;
    rdy[d]     = r;
    sf[d]      = s;
    pf[d]      = p;
  endtask

  task automatic dec_test(input logic [31:0] pc, input logic [31:0] inst);
    drv(0, 1'b1, pc, inst, 1'b1, 1'b0, 1'b0);
    drv(0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    vld = '0;
    rdy = 2'b11;
    sf  = '0;
    pf  = '0;
    for (int i = 0; i < 2; i++) begin
      pc_in[i]   = '0;
      inst_in[i] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(m[0].o_valid), 64'd0);
    chk("rst_ready", 64'(m[0].o_ready), 64'd1);
    chk("rst_op", 64'(m[0].o_op), 64'hF);

    dec_test(32'h100, 32'h212F_FFFF);
    chk("addi_dr", 64'(m[0].o_dr), 64'd1);
    chk("addi_sr1", 64'(m[0].o_sr1), 64'd2);
    chk("addi_sr2", 64'(m[0].o_sr2), 64'd0);
    chk("addi_imm", 64'(m[0].o_imm), 64'hFFFF_FFFF);
    dec_test(32'h200, 32'h8123_0004);
    chk("skp_mode", 64'(m[0].o_skp), 64'd1);
    chk("skp_sr1", 64'(m[0].o_sr1), 64'd2);
    chk("skp_sr2", 64'(m[0].o_sr2), 64'd4);
    dec_test(32'h0010, 32'h5000_FFF0);
    chk("goto_wrap", 64'(m[0].o_imm), 64'd0);
    dec_test(32'h1234, 32'h9300_0100);
    chk("lea_dr", 64'(m[0].o_dr), 64'd3);
    chk("lea_imm", 64'(m[0].o_imm), 64'h1334);
    dec_test(32'h40, 32'hA000_0000);
    chk("illegal", 64'(m[0].o_ill), 64'd1);
    chk("illegal_op", 64'(m[0].o_op), 64'hA);
    chk("illegal_imm", 64'(m[0].o_imm), 64'd0);
    dec_test(32'h44, 32'h7000_0000);
    chk("halt_legal", 64'(m[0].o_ill), 64'd0);

    // Backpressure through the skid entry, then a stage flush while full.
    drv(0, 1'b1, 32'hA0, 32'h0123_0005, 1'b0, 1'b0, 1'b0);
    drv(0, 1'b1, 32'hB0, 32'h1456_000A, 1'b0, 1'b0, 1'b0);
    drv(0, 1'b1, 32'hC0, 32'h4789_000F, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready_low", 64'(m[0].o_ready), 64'd0);
    chk("bp_head_a", 64'(m[0].o_op), 64'h0);
    drv(0, 1'b1, 32'hC0, 32'h4789_000F, 1'b1, 1'b0, 1'b0);
    drv(0, 1'b1, 32'hC0, 32'h4789_000F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_head_b", 64'(m[0].o_op), 64'h1);
    chk("bp_ready_back", 64'(m[0].o_ready), 64'd1);
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_head_c", 64'(m[0].o_op), 64'h4);
    drv(0, 1'b1, 32'hE0, 32'h2ABC_DEF0, 1'b0, 1'b0, 1'b0);
    drv(0, 1'b1, 32'hD0, 32'h6DEF_0000, 1'b0, 1'b1, 1'b0);
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_valid", 64'(m[0].o_valid), 64'd0);
    chk("flush_op", 64'(m[0].o_op), 64'hF);
    chk("flush_ready", 64'(m[0].o_ready), 64'd1);
    drv(0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("pipe_flush_out", 64'(m[0].o_pipe_flush), 64'd1);

    // Reset while holding one instruction.
    drv(0, 1'b1, 32'h300, 32'h3111_2222, 1'b0, 1'b0, 1'b0);
    drv(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(m[0].o_valid), 64'd0);
    chk("mid_rst_pc", 64'(m[0].o_pc), 64'd0);
    chk("mid_rst_op", 64'(m[0].o_op), 64'hF);

    // Single-entry instance: o_ready follows !o_valid || i_ready.
    drv(1, 1'b1, 32'hA0, 32'h0123_0005, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b1, 32'hB0, 32'h1456_000A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ns_ready_low", 64'(m[1].o_ready), 64'd0);
    drv(1, 1'b1, 32'hB0, 32'h1456_000A, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ns_ready_comb", 64'(m[1].o_ready), 64'd1);
    drv(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ns_head_b", 64'(m[1].o_op), 64'h1);
    drv(1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      rst = ($urandom_range(0, 599) == 0);
      for (int d = 0; d < 2; d++) begin
        if (!(vld[d] && !accv[d])) begin
          vld[d]     = ($urandom_range(0, 9) < 7);
          pc_in[d]   = $urandom;
          inst_in[d] = $urandom;
        end
        rdy[d] = ($urandom_range(0, 9) < 6);
        sf[d]  = ($urandom_range(0, 39) == 0);
        pf[d]  = ($urandom_range(0, 69) == 0);
      end
    end
    @(posedge clk);
    #2;
    vld = '0;
    sf  = '0;
    pf  = '0;
    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl45_decode_hs.md
# tl45_decode_hs

Parametrised TL45 decode stage with a valid/ready handshake, placed between fetch and register-read. It replaces the global-stall decode: each instruction is decoded combinationally on entry and held in an output register. An optional skid entry lets upstream `o_ready` come straight from a register. The block also flags illegal opcodes, uses a configurable datapath width and a configurable PC-relative address width, and keeps the existing stage and pipe flush semantics.

## Interface
Parameters:
- `XLEN`, 32: datapath width of `o_buf_pc` and `o_buf_imm`. Must be ≥ 32.
- `ADDR_BITS`, 16: width of the PC-relative target for GOTO and LEA. Range 1..20.
- `SKID_EN`, 1: selects the buffering mode.
  - 1: two entries (output plus skid); `o_ready` is registered.
  - 0: single entry; `o_ready = !o_valid || i_ready`, combinational.

Ports:
- `i_clk`  in  1  clock. Single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_stage_flush`  in  1  flush this stage only.
- `i_pipe_flush`  in  1  whole-pipe flush.
- `o_pipe_flush`  out  1  equals `i_pipe_flush`, combinational.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  block can accept an instruction.
- `i_buf_pc`  in  XLEN  fetch PC.
- `i_buf_inst`  in  32  fetched instruction.
- `o_valid`  out  1  decoded instruction available.
- `i_ready`  in  1  downstream accepts.
- `o_buf_pc`  out  XLEN  PC of the decoded instruction.
- `o_buf_opcode`  out  4  `inst[31:28]`, or 4'hF for a bubble.
- `o_buf_skp_mode`  out  1  `inst[24]`.
- `o_buf_dr`, `o_buf_sr1`, `o_buf_sr2`  out  4 each  register indices.
- `o_buf_imm`  out  XLEN  immediate or target.
- `o_buf_illegal`  out  1  opcode is in the range 4'hA..4'hF.

## Operation
Decode is combinational on `i_buf_inst`. Opcode values:
- ADD = 0, NAND = 1: dr = [27:24], sr1 = [23:20], sr2 = [3:0], imm = 0.
- ADDI = 2, LW = 3: dr = [27:24], sr1 = [23:20], sr2 = 0, imm = sext(`inst[19:0]`) to XLEN.
- SW = 4: dr = 0, sr1 = [23:20], sr2 = [27:24], imm = sext(`inst[19:0]`).
- GOTO = 5: dr = sr1 = sr2 = 0. imm = zext((`pc[ADDR_BITS-1:0]` + `inst[ADDR_BITS-1:0]`) mod 2^ADDR_BITS) to XLEN.
- LEA = 9: dr = [27:24], sr1 = sr2 = 0, imm as for GOTO.
- JALR = 6: dr = [27:24], sr1 = [23:20], sr2 = 0, imm = 0.
- SKP = 8: dr = 0, sr1 = [23:20], sr2 = [3:0], imm = 0.
- HALT = 7: all register fields and imm = 0, illegal = 0.
- Opcodes 4'hA..4'hF: all register fields and imm = 0, illegal = 1, and the opcode is passed through unchanged.

Handshake:
- accept = `i_valid && o_ready`.
- drain = `o_valid && i_ready`.
- The upstream side must hold `i_buf_*` stable while `i_valid && !o_ready`.

Buffer FSM for `SKID_EN` = 1:
- EMPTY: `o_valid` = 0, `o_ready` = 1. On accept, load the output entry and go to ONE.
- ONE: `o_valid` = 1, `o_ready` = 1.
  - accept and drain: load the output entry and stay in ONE.
  - accept only: load the skid entry and go to FULL.
  - drain only: go to EMPTY.
- FULL: `o_valid` = 1, `o_ready` = 0. On drain, move the skid entry to the output entry and go to ONE.

With `SKID_EN` = 0 there are only EMPTY and ONE, and the FULL transition never occurs.

Flush:
- flush = `i_reset || i_stage_flush || i_pipe_flush`.
- Flush has priority over everything else. Next state is EMPTY, and both entries take their bubble values.
- An instruction presented in the flush cycle is discarded, even if accept was high.

Bubble and reset values:
- pc = 0, opcode = 4'hF, imm = 0, every other output field = 0.
- `o_valid` = 0.
- `o_ready` = 1. This also holds in the cycle after reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on `o_buf_*` with `o_valid` after edge N.
- Throughput is one instruction per cycle when `i_ready` is held at 1.
- With `SKID_EN` = 1, `o_ready` depends only on state. It drops the cycle after the second accept under backpressure and rises the cycle after a drain out of FULL.
- Output registers change only on an accept into the output entry, a skid-to-output move, or a flush. Output data is stable while `o_valid && !i_ready`.
- Ordering is strict FIFO, with no loss or duplication.

## Structure
- Package `tl45_pkg` holds the shared definitions:
  - opcode localparams `OP_ADD` .. `OP_LEA`;
  - `OP_BUBBLE` = 4'hF;
  - a `decoded_t` struct (pc, opcode, skp_mode, dr, sr1, sr2, imm, illegal);
  - the buffer-state enum.
- Sub-module `tl45_inst_decoder` is purely combinational: inst plus pc in, `decoded_t` out, parametrised on XLEN and ADDR_BITS. The top level holds the FSM and two `decoded_t` registers.

## Test plan
- Field decode: ADDI `0x212FFFFF` → dr = 1, sr1 = 2, sr2 = 0, imm = 0xFFFFFFFF. SKP `0x81230004` → skp_mode = 1, sr1 = 2, sr2 = 4.
- GOTO wrap: pc = 0x0010, inst `0x5000FFF0` → imm = 0x0. LEA: pc = 0x1234, inst `0x93000100` → dr = 3, imm = 0x1334.
- Illegal opcode: inst `0xA0000000` → illegal = 1, opcode = 4'hA, all fields 0. HALT `0x70000000` → illegal = 0.
- Backpressure, `SKID_EN` = 1: send A, B, C back to back with `i_ready` = 0.
  - A and B are accepted, `o_ready` goes low, and C is held.
  - Raising `i_ready` drains A, B, C in order; `o_ready` returns high.
- Flush in FULL: assert `i_stage_flush` for one cycle, with `i_valid` high on a new instruction D.
  - Next cycle: `o_valid` = 0, opcode = 4'hF, `o_ready` = 1. D does not appear.
  - `o_pipe_flush` follows `i_pipe_flush` in the same cycle.
- Reset mid-stream: assert `i_reset` while in ONE → all outputs take reset values next edge. Repeat the backpressure test with `SKID_EN` = 0 and check `o_ready` = `!o_valid || i_ready`.
